// File: rtl/meas_pkg.sv
// rtl/meas_pkg.sv - shared state encoding, width defaults and sum sizing for the window meter
package meas_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    ACCUM   = 3'd3,
    REPORT  = 3'd4
  } state_t;

  localparam int DATA_W_DEF = 12;

  // Wide enough to hold num_avg full-scale window results without wrap.
  function automatic int sum_width(input int data_w, input int num_avg);
    return data_w + $clog2(num_avg);
  endfunction

endpackage

// File: rtl/minmax_tracker.sv
// rtl/minmax_tracker.sv - running minimum/maximum of qualified samples within one window
module minmax_tracker
  import meas_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val
);

  // Clear wins over valid so a new window never inherits the previous extremes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_val <= '0;
      max_val <= '0;
    end else if (clear) begin
      min_val <= '1;
      max_val <= '0;
    end else if (valid) begin
      if (sample < min_val) min_val <= sample;
      if (sample > max_val) max_val <= sample;
    end
  end

endmodule

// File: rtl/meas_window_ctrl.sv
// rtl/meas_window_ctrl.sv - settles, captures NUM_AVG windows of min/max and reports their averages
module meas_window_ctrl
  import meas_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WIN_LEN    = 1000000,
  parameter int SETTLE_LEN = 5000000,
  parameter int NUM_AVG    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              res_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_vpp,
  output logic              busy,
  output logic              overrun
);

  localparam int AVG_SH = $clog2(NUM_AVG);
  localparam int SUM_W  = sum_width(DATA_W, NUM_AVG);
  localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int SET_W  = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
  localparam int IDX_W  = (AVG_SH > 0) ? AVG_SH : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_LEN > 1) ? SETTLE_LEN - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_AVG - 1);

  state_t            state, state_nxt;
  logic              cap_start;
  logic              accept;
  logic              xfer;
  logic [SET_W-1:0]  settle_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [IDX_W-1:0]  win_idx;
  logic [SUM_W-1:0]  sum_max, sum_min;
  logic [DATA_W-1:0] trk_min, trk_max;
  logic [DATA_W-1:0] avg_max, avg_min;
  logic              overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE: begin
        if (!enable)                    state_nxt = IDLE;
        else if (settle_cnt == SET_LAST) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!enable)                                  state_nxt = IDLE;
        else if (sample_valid && win_cnt == WIN_LAST) state_nxt = ACCUM;
      end
      ACCUM:   state_nxt = (win_idx == IDX_LAST) ? REPORT : CAPTURE;
      REPORT:  if (res_ready) state_nxt = enable ? CAPTURE : IDLE;
      default: state_nxt = IDLE;
    endcase
    cap_start = (state_nxt == CAPTURE) && (state != CAPTURE);
    accept    = (state == CAPTURE) && sample_valid;
    xfer      = (state == REPORT) && res_ready;
  end

  minmax_tracker #(.DATA_W(DATA_W)) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clear   (cap_start),
    .valid   (accept),
    .sample  (sample),
    .min_val (trk_min),
    .max_val (trk_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      win_idx    <= '0;
      sum_max    <= '0;
      sum_min    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                 settle_cnt <= '0;

      if (cap_start)   win_cnt <= '0;
      else if (accept) win_cnt <= win_cnt + 1'b1;

      // Leaving IDLE or completing a handshake both start a fresh averaging run.
      if (state == IDLE || xfer) begin
        sum_max <= '0;
        sum_min <= '0;
        win_idx <= '0;
      end else if (state == ACCUM) begin
        sum_max <= sum_max + SUM_W'(trk_max);
        sum_min <= sum_min + SUM_W'(trk_min);
        win_idx <= win_idx + 1'b1;
      end

      if (state == IDLE && enable)             overrun_q <= 1'b0;
      else if (state == REPORT && sample_valid) overrun_q <= 1'b1;
    end
  end

  assign avg_max   = DATA_W'(sum_max >> AVG_SH);
  assign avg_min   = DATA_W'(sum_min >> AVG_SH);
  assign res_valid = (state == REPORT);
  assign res_max   = res_valid ? avg_max : '0;
  assign res_min   = res_valid ? avg_min : '0;
  assign res_vpp   = res_max - res_min;
  assign busy      = (state != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_meas_window_ctrl.sv
// tb/tb_meas_window_ctrl.sv - scoreboard bench for meas_window_ctrl (WIN_LEN=4, SETTLE_LEN=2, NUM_AVG=2)
module tb_meas_window_ctrl;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          res_ready = 1'b1;
  logic          res_valid, busy, overrun;
  logic [DW-1:0] res_max, res_min, res_vpp;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    logic [DW-1:0] vpp;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  meas_window_ctrl #(
    .DATA_W(DW), .WIN_LEN(4), .SETTLE_LEN(2), .NUM_AVG(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample       (sample),
    .res_ready    (res_ready),
    .res_valid    (res_valid),
    .res_max      (res_max),
    .res_min      (res_min),
    .res_vpp      (res_vpp),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int win_max(input int w[8], input int base);
    int m = 0;
    for (int i = 0; i < 4; i++) if (w[base+i] > m) m = w[base+i];
    return m;
  endfunction

  function automatic int win_min(input int w[8], input int base);
    int m = 4095;
    for (int i = 0; i < 4; i++) if (w[base+i] < m) m = w[base+i];
    return m;
  endfunction

  task automatic push_expected(input int w[8]);
    exp_t e;
    e.mx  = DW'((win_max(w, 0) + win_max(w, 4)) / 2);
    e.mn  = DW'((win_min(w, 0) + win_min(w, 4)) / 2);
    e.vpp = e.mx - e.mn;
    exp_q.push_back(e);
  endtask

  // IDLE -> SETTLE takes one clock, SETTLE two more; samples offered meanwhile must be ignored.
  task automatic start_enable();
    enable       = 1'b1;
    sample_valid = 1'b1;
    sample       = 12'hFFF;
    repeat (3) tick();
    sample_valid = 1'b0;
  endtask

  task automatic feed_window(input int w[8], input int base, input bit toggle);
    for (int i = 0; i < 4; i++) begin
      if (toggle) begin
        sample_valid = 1'b0;
        sample       = (i % 2 == 0) ? 12'hFFF : 12'h000;
        tick();
      end
      sample_valid = 1'b1;
      sample       = DW'(w[base+i]);
      tick();
    end
    sample_valid = 1'b1;
    sample       = 12'hFFF;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic feed_pair(input int w[8], input bit toggle);
    push_expected(w);
    feed_window(w, 0, toggle);
    feed_window(w, 4, toggle);
  endtask

  task automatic wait_result(input bit keep_en, input string name);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: res_valid=%b queued=%0d, required res_valid=1 with a queued result",
               name, res_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (res_max !== e.mx) begin
        n_fail++; $display("FAIL %s_max: got %0d, required %0d", name, res_max, e.mx);
      end
      n_checks++;
      if (res_min !== e.mn) begin
        n_fail++; $display("FAIL %s_min: got %0d, required %0d", name, res_min, e.mn);
      end
      n_checks++;
      if (res_vpp !== e.vpp) begin
        n_fail++; $display("FAIL %s_vpp: got %0d, required %0d", name, res_vpp, e.vpp);
      end
      enable = keep_en;
      tick();
      n_checks++;
      if (res_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s_pulse: res_valid=%b after transfer, required 0", name, res_valid);
      end
      n_checks++;
      if (busy !== keep_en) begin
        n_fail++; $display("FAIL %s_busy: busy=%b after transfer, required %b", name, busy, keep_en);
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_checks++;
    if ({res_valid, busy, overrun} !== 3'b000 || res_max !== '0 || res_min !== '0 || res_vpp !== '0) begin
      n_fail++;
      $display("FAIL %s: valid=%b busy=%b overrun=%b max=%0d min=%0d vpp=%0d, required all 0",
               name, res_valid, busy, overrun, res_max, res_min, res_vpp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    check_zero_outputs("reset_hold");
    rst = 1'b1;
    tick();
    check_zero_outputs("reset_release");
  endtask

  task automatic test_basic();
    int w[8];
    w = '{100, 900, 500, 300, 200, 700, 400, 600};
    start_enable();
    feed_pair(w, 1'b0);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL basic_accum_drop: overrun=%b, required 0", overrun);
    end
    wait_result(1'b0, "basic");
  endtask

  task automatic test_toggle();
    int w[8];
    w = '{100, 900, 500, 300, 200, 700, 400, 600};
    start_enable();
    feed_pair(w, 1'b1);
    wait_result(1'b0, "toggle");
  endtask

  task automatic test_back_to_back();
    int w[8];
    int w2[8];
    exp_t e;
    w  = '{1200, 3300, 40, 2500, 800, 900, 1000, 1100};
    w2 = '{50, 60, 70, 80, 10, 4000, 20, 30};
    start_enable();
    res_ready = 1'b0;
    feed_pair(w, 1'b0);
    e = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample       = DW'($urandom_range(4095, 0));
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || res_max !== e.mx || res_min !== e.mn || res_vpp !== e.vpp) begin
        n_fail++;
        $display("FAIL hold_%0d: valid=%b max=%0d min=%0d vpp=%0d, required 1 %0d %0d %0d",
                 i, res_valid, res_max, res_min, res_vpp, e.mx, e.mn, e.vpp);
      end
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set: overrun=%b, required 1", overrun);
    end
    sample_valid = 1'b0;
    res_ready    = 1'b1;
    wait_result(1'b1, "held_xfer");
    feed_pair(w2, 1'b0);
    wait_result(1'b0, "no_settle");
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: overrun=%b in idle, required 1", overrun);
    end
  endtask

  task automatic test_abort();
    int w[8];
    int pulses = 0;
    w = '{1000, 1001, 999, 1000, 2, 3, 4, 5};
    start_enable();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: overrun=%b after enable, required 0", overrun);
    end
    sample_valid = 1'b1; sample = 12'd3000; tick();
    sample = 12'd5; tick();
    sample_valid = 1'b0;
    enable = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", busy, res_valid);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL abort_no_result: %0d res_valid cycles, required 0", pulses);
    end
    start_enable();
    feed_pair(w, 1'b0);
    wait_result(1'b0, "after_abort");
  endtask

  task automatic test_reset_report();
    int w[8];
    exp_t e;
    w = '{10, 20, 30, 40, 50, 60, 70, 80};
    start_enable();
    res_ready = 1'b0;
    feed_pair(w, 1'b0);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_checks++;
    if (res_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_report: valid=%b overrun=%b, required 1 1", res_valid, overrun);
    end
    #2 rst = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    if (exp_q.size() != 0) e = exp_q.pop_front();
    @(negedge clk);
    rst       = 1'b1;
    res_ready = 1'b1;
    enable    = 1'b0;
    tick();
    check_zero_outputs("post_reset_idle");
  endtask

  task automatic test_full_scale();
    int w[8];
    for (int i = 0; i < 8; i++) w[i] = 4095;
    start_enable();
    feed_pair(w, 1'b0);
    wait_result(1'b0, "full_scale");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_back_to_back();
    test_abort();
    test_reset_report();
    test_full_scale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
